// File: rtl/axibram_page_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : axibram_page_ctrl_if
// Description : Signal bundle between the BRAM page-ownership controller and
//               its neighbours (AXI read engine, local producer, software
//               command/status registers).
//               master : read engine / producer / software side
//               slave  : axibram_page_ctrl
//               Read engine : pre_araddr, start_burst, rd_busy -> dev_ready
//               Producer    : wpage_done -> wpage, wpage_ready
//               Software    : release_we, release_page, flush
//                             -> full_mask, overrun_cnt, release_err,
//                                timeout_flag
// Revision    : 1.0 - initial release
// ============================================================================
interface axibram_page_ctrl_if #(
    parameter int ADDRESS_BITS = 10,
    parameter int PAGE_BITS    = 2
);
    logic [ADDRESS_BITS-1:0]   pre_araddr;
    logic                      start_burst;
    logic                      rd_busy;
    logic                      dev_ready;
    logic [PAGE_BITS-1:0]      wpage;
    logic                      wpage_ready;
    logic                      wpage_done;
    logic                      release_we;
    logic [PAGE_BITS-1:0]      release_page;
    logic                      flush;
    logic [2**PAGE_BITS-1:0]   full_mask;
    logic [7:0]                overrun_cnt;
    logic                      release_err;
    logic                      timeout_flag;

    modport master (
        output pre_araddr, start_burst, rd_busy, wpage_done,
               release_we, release_page, flush,
        input  dev_ready, wpage, wpage_ready, full_mask,
               overrun_cnt, release_err, timeout_flag
    );

    modport slave (
        input  pre_araddr, start_burst, rd_busy, wpage_done,
               release_we, release_page, flush,
        output dev_ready, wpage, wpage_ready, full_mask,
               overrun_cnt, release_err, timeout_flag
    );
endinterface
`default_nettype wire

// File: rtl/axibram_page_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axibram_page_ctrl
// Description : Page-ownership controller for a BRAM shared between a local
//               producer and an AXI read engine. The BRAM is split into
//               2^PAGE_BITS pages filled in ring order; software releases
//               pages after reading them. dev_ready stalls AXI reads into a
//               page that is not yet full.
// Ports       : aclk  - clock
//               arst  - synchronous active-high reset
//               bus   - axibram_page_ctrl_if.slave (read engine, producer and
//                       software command/status signals)
// Options     : `define AXIBRAM_PAGE_TIMEOUT_EN builds a stall-timeout
//               counter that forces dev_ready after 2^TIMEOUT_BITS-1 stall
//               cycles so a burst into an empty page cannot hang the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module axibram_page_ctrl #(
    parameter int ADDRESS_BITS = 10,
    parameter int PAGE_BITS    = 2,
    parameter int TIMEOUT_BITS = 12
) (
    input  wire logic             aclk,
    input  wire logic             arst,
    axibram_page_ctrl_if.slave    bus
);

    localparam int c_pages = 2**PAGE_BITS;

    logic [PAGE_BITS-1:0] r_rpage;
    logic [PAGE_BITS-1:0] r_wpage;
    logic [c_pages-1:0]   r_full_mask;
    logic [7:0]           r_overrun_cnt;
    logic                 r_release_err;

    logic                 w_clear;
    logic                 w_wpage_free;
    logic                 w_mark;
    logic                 w_rel_ok;
    logic                 w_rel_bad;
    logic                 w_overrun;
    logic [c_pages-1:0]   w_set_vec;
    logic [c_pages-1:0]   w_clr_vec;
    logic                 w_force_ready;
    logic                 w_timeout_flag;
    logic                 w_dev_ready;

    assign w_clear = arst | bus.flush;

    // A legal release only targets a full page and a mark only targets a free
    // one, so set and clear vectors never overlap. A release aimed at a free
    // wpage therefore falls into w_rel_bad while the mark still goes ahead.
    always_comb begin
        w_wpage_free = ~r_full_mask[r_wpage];
        w_mark       = bus.wpage_done & w_wpage_free;
        w_overrun    = bus.wpage_done & ~w_wpage_free;
        w_rel_ok     = bus.release_we & r_full_mask[bus.release_page];
        w_rel_bad    = bus.release_we & ~r_full_mask[bus.release_page];
        w_set_vec    = '0;
        w_clr_vec    = '0;
        w_set_vec[r_wpage]          = w_mark;
        w_clr_vec[bus.release_page] = w_rel_ok;
    end

    always_ff @(posedge aclk) begin
        if (w_clear) begin
            r_rpage       <= '0;
            r_wpage       <= '0;
            r_full_mask   <= '0;
            r_overrun_cnt <= '0;
            r_release_err <= 1'b0;
        end else begin
            if (bus.start_burst)
                r_rpage <= bus.pre_araddr[ADDRESS_BITS-1 -: PAGE_BITS];
            r_full_mask <= (r_full_mask & ~w_clr_vec) | w_set_vec;
            if (w_mark)
                r_wpage <= r_wpage + PAGE_BITS'(1);
            if (w_overrun && r_overrun_cnt != 8'hFF)
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            if (w_rel_bad)
                r_release_err <= 1'b1;
        end
    end

    // Registers only: no same-cycle path from start_burst/pre_araddr, which
    // would close a loop through the read engine's ready logic.
    assign w_dev_ready = r_full_mask[r_rpage] | w_force_ready;

`ifdef AXIBRAM_PAGE_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] c_to_max = '1;

    logic [TIMEOUT_BITS-1:0] r_to_cnt;
    logic                    r_force_ready;
    logic                    r_timeout_flag;
    logic                    w_stall;

    assign w_stall = bus.rd_busy & ~w_dev_ready;

    // Timeout fires as the counter steps onto its all-ones value; the forced
    // ready then holds until the burst ends or a new one starts.
    always_ff @(posedge aclk) begin
        if (w_clear) begin
            r_to_cnt       <= '0;
            r_force_ready  <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (bus.start_burst || !bus.rd_busy || w_dev_ready)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TIMEOUT_BITS'(1);

            if (bus.start_burst || !bus.rd_busy) begin
                r_force_ready <= 1'b0;
            end else if (w_stall && r_to_cnt == c_to_max - TIMEOUT_BITS'(1)) begin
                r_force_ready  <= 1'b1;
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign w_force_ready  = r_force_ready;
    assign w_timeout_flag = r_timeout_flag;
`else
    assign w_force_ready  = 1'b0;
    assign w_timeout_flag = 1'b0;

    wire                    w_unused_rd_busy = bus.rd_busy;
    wire [TIMEOUT_BITS-1:0] w_unused_to_cnt  = '0;
`endif

    wire w_unused_addr = &{1'b0, bus.pre_araddr[ADDRESS_BITS-PAGE_BITS-1:0]};

    assign bus.dev_ready    = w_dev_ready;
    assign bus.wpage        = r_wpage;
    assign bus.wpage_ready  = ~r_full_mask[r_wpage];
    assign bus.full_mask    = r_full_mask;
    assign bus.overrun_cnt  = r_overrun_cnt;
    assign bus.release_err  = r_release_err;
    assign bus.timeout_flag = w_timeout_flag;

endmodule
`default_nettype wire
